// File: rtl/top_bus.sv
// top_bus: two-port packet interconnect; per-device ingress/egress FIFOs joined by a
// round-robin arbiter that moves at most one packet per clock.
module bus_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wp_q[AW-1:0]] = din;
    wp_d  = wr ? wp_q + ONE : wp_q;
    rp_d  = rd ? rp_q + ONE : rp_q;
    empty = wp_q == rp_q;
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    dout  = empty ? '0 : mem_q[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end
endmodule

module top_bus #(
  parameter int          PCKG_SZ   = 65,
  parameter int          DEPTH     = 8,
  parameter logic [2:0]  BROADCAST = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_device0,
  input  logic               push_device1,
  input  logic [PCKG_SZ-1:0] D_push_device0,
  input  logic [PCKG_SZ-1:0] D_push_device1,
  input  logic               pop_device0,
  input  logic               pop_device1,
  output logic [PCKG_SZ-1:0] D_pop_device0,
  output logic [PCKG_SZ-1:0] D_pop_device1,
  output logic               pndng_device0,
  output logic               pndng_device1
);
  logic [1:0]         push, pop, in_wr, in_rd, in_empty, in_full;
  logic [1:0]         out_wr, out_rd, out_empty, out_full, space, can;
  logic [1:0]         tgt [2];
  logic [2:0]         dest [2];
  logic [PCKG_SZ-1:0] in_din [2];
  logic [PCKG_SZ-1:0] in_head [2];
  logic [PCKG_SZ-1:0] out_head [2];
  logic [PCKG_SZ-1:0] xfer;
  logic               rr_q, rr_d, gnt, gnt_v;
  assign push      = {push_device1, push_device0};
  assign pop       = {pop_device1, pop_device0};
  assign in_din[0] = D_push_device0;
  assign in_din[1] = D_push_device1;
  assign in_wr     = push & ~in_full;
  assign out_rd    = pop & ~out_empty;
  for (genvar i = 0; i < 2; i++) begin : g_port
    bus_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_in (
      .clk(clk), .reset(reset), .wr(in_wr[i]), .rd(in_rd[i]), .din(in_din[i]),
      .dout(in_head[i]), .empty(in_empty[i]), .full(in_full[i])
    );
    bus_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_out (
      .clk(clk), .reset(reset), .wr(out_wr[i]), .rd(out_rd[i]), .din(xfer),
      .dout(out_head[i]), .empty(out_empty[i]), .full(out_full[i])
    );
  end
  assign D_pop_device0 = out_head[0];
  assign D_pop_device1 = out_head[1];
  assign pndng_device0 = ~out_empty[0];
  assign pndng_device1 = ~out_empty[1];
  // A full egress still accepts a write in the cycle its own device pops it.
  always_comb begin
    space = ~out_full | pop;
    for (int p = 0; p < 2; p++) begin
      dest[p] = in_head[p][PCKG_SZ-1 -: 3];
      tgt[p]  = dest[p] == 3'd0      ? 2'b01 :
                dest[p] == 3'd1      ? 2'b10 :
                dest[p] == BROADCAST ? (p == 0 ? 2'b10 : 2'b01) : 2'b00;
      can[p]  = ~in_empty[p] & ((tgt[p] & ~space) == 2'b00);
    end
    gnt_v  = |can;
    gnt    = can[rr_q] ? rr_q : ~rr_q;
    rr_d   = gnt_v ? ~gnt : rr_q;
    in_rd  = gnt_v ? 2'b01 << gnt : 2'b00;
    out_wr = gnt_v ? tgt[gnt] : 2'b00;
    xfer   = in_head[gnt];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
endmodule

// File: tb/tb_top_bus.sv
// tb_top_bus: directed scoreboard bench for top_bus; expected packets are queued per
// destination when driven and popped when the device drains its egress FIFO.
module tb_top_bus;
  localparam int N = 30;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push_device0 = 1'b0, push_device1 = 1'b0;
  logic        pop_device0 = 1'b0, pop_device1 = 1'b0;
  logic [64:0] D_push_device0 = '0, D_push_device1 = '0;
  logic [64:0] D_pop_device0, D_pop_device1;
  logic        pndng_device0, pndng_device1;
  int          errors = 0, checks = 0;
  logic [64:0] q0[$], q1[$];
  logic [64:0] pkt, e, r;
  int          last_rx, rx_cnt;
  logic        prev1;

  always #5 clk = ~clk;

  top_bus dut (
    .clk(clk), .reset(reset),
    .push_device0(push_device0), .push_device1(push_device1),
    .D_push_device0(D_push_device0), .D_push_device1(D_push_device1),
    .pop_device0(pop_device0), .pop_device1(pop_device1),
    .D_pop_device0(D_pop_device0), .D_pop_device1(D_pop_device1),
    .pndng_device0(pndng_device0), .pndng_device1(pndng_device1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input int dev, input logic [64:0] p);
    if (dev == 0) begin push_device0 = 1'b1; D_push_device0 = p; end
    else begin push_device1 = 1'b1; D_push_device1 = p; end
    if (p[64:62] == 3'd0 || (p[64:62] == 3'b111 && dev == 1)) q0.push_back(p);
    if (p[64:62] == 3'd1 || (p[64:62] == 3'b111 && dev == 0)) q1.push_back(p);
    tick();
    push_device0 = 1'b0;
    push_device1 = 1'b0;
  endtask

  task automatic pop_one(input int dev);
    logic [64:0] x;
    x = '1;
    if (dev == 0) begin
      if (q0.size() > 0) x = q0.pop_front();
      chk("pop0_data", D_pop_device0, x);
      pop_device0 = 1'b1;
    end else begin
      if (q1.size() > 0) x = q1.pop_front();
      chk("pop1_data", D_pop_device1, x);
      pop_device1 = 1'b1;
    end
    tick();
    pop_device0 = 1'b0;
    pop_device1 = 1'b0;
  endtask

  task automatic drain(input int dev);
    int n;
    n = 0;
    while (n < 40 && (dev == 0 ? q0.size() : q1.size()) != 0) begin
      if (dev == 0 ? pndng_device0 : pndng_device1) pop_one(dev);
      else tick();
      n++;
    end
    chk("drain_left", 65'(dev == 0 ? q0.size() : q1.size()), 65'd0);
    chk("drain_pndng", 65'(dev == 0 ? pndng_device0 : pndng_device1), 65'd0);
    chk("drain_dpop", dev == 0 ? D_pop_device0 : D_pop_device1, 65'd0);
  endtask

  initial begin
    // reset held low for three cycles, with a push that must be ignored
    #1 reset = 1'b0;
    push_device0 = 1'b1;
    D_push_device0 = {3'b001, 2'b00, 60'h5};
    tick(); tick(); tick();
    reset = 1'b1;
    push_device0 = 1'b0;
    chk("rst_pndng0", 65'(pndng_device0), 65'd0);
    chk("rst_pndng1", 65'(pndng_device1), 65'd0);
    chk("rst_dpop0", D_pop_device0, 65'd0);
    chk("rst_dpop1", D_pop_device1, 65'd0);
    pop_device0 = 1'b1;
    pop_device1 = 1'b1;
    tick(); tick();
    pop_device0 = 1'b0;
    pop_device1 = 1'b0;
    chk("rst_pop_pndng0", 65'(pndng_device0), 65'd0);
    chk("rst_pop_pndng1", 65'(pndng_device1), 65'd0);
    chk("rst_pop_dpop1", D_pop_device1, 65'd0);

    // unicast 0->1 with two-cycle latency
    pkt = {3'b001, 2'b00, 60'hFFF_FFFF_FFFF_FFFF};
    send(0, pkt);
    chk("uni_k_pndng1", 65'(pndng_device1), 65'd0);
    tick();
    chk("uni_k1_pndng1", 65'(pndng_device1), 65'd1);
    pop_one(1);
    chk("uni_k2_pndng1", 65'(pndng_device1), 65'd0);
    chk("uni_k2_dpop1", D_pop_device1, 65'd0);

    // self-addressed loopback
    send(0, {3'b000, 2'b00, 60'hABC});
    tick();
    chk("loop_pndng1", 65'(pndng_device1), 65'd0);
    drain(0);

    // broadcast from each side reaches only the other device
    send(1, {3'b111, 2'b01, 60'h123_4567});
    tick();
    chk("bc1_pndng1", 65'(pndng_device1), 65'd0);
    chk("bc1_pndng0", 65'(pndng_device0), 65'd1);
    tick();
    chk("bc1_pndng1_late", 65'(pndng_device1), 65'd0);
    drain(0);
    send(0, {3'b111, 2'b00, 60'h89A_BCDE});
    tick();
    chk("bc0_pndng0", 65'(pndng_device0), 65'd0);
    drain(1);

    // unpopulated destinations are dropped; the following packet still flows
    send(0, {3'b010, 2'b00, 60'h1});
    send(1, {3'b110, 2'b01, 60'h2});
    send(0, {3'b001, 2'b00, 60'h3});
    tick(); tick(); tick();
    chk("inv_pndng0", 65'(pndng_device0), 65'd0);
    drain(1);

    // bidirectional streaming: device 1 answers every packet it receives
    last_rx = -1;
    rx_cnt = 0;
    prev1 = 1'b0;
    for (int c = 0; c < N + 40; c++) begin
      if (c >= 4 && c <= N) begin
        chk("alt_dev1", 65'(pndng_device1), 65'(!prev1));
        chk("alt_excl", 65'(pndng_device0), 65'(!pndng_device1));
      end
      prev1 = pndng_device1;
      push_device1 = 1'b0;
      pop_device1 = 1'b0;
      pop_device0 = 1'b0;
      if (pndng_device0) begin
        e = '1;
        if (q0.size() > 0) e = q0.pop_front();
        chk("stream_reply", D_pop_device0, e);
        pop_device0 = 1'b1;
      end
      if (pndng_device1) begin
        chk("stream_hdr", 65'(D_pop_device1[64:32]), 65'({5'b00100, 28'hA5A5A5A}));
        chk("stream_order", 65'(int'(D_pop_device1[31:0]) > last_rx), 65'd1);
        last_rx = int'(D_pop_device1[31:0]);
        rx_cnt++;
        r = {3'b000, 2'b01, D_pop_device1[59:0]};
        push_device1 = 1'b1;
        D_push_device1 = r;
        q0.push_back(r);
        pop_device1 = 1'b1;
      end
      push_device0 = c < N;
      D_push_device0 = {3'b001, 2'b00, 28'hA5A5A5A, 32'(c)};
      tick();
    end
    push_device0 = 1'b0;
    push_device1 = 1'b0;
    pop_device0 = 1'b0;
    pop_device1 = 1'b0;
    chk("stream_dropped", 65'(rx_cnt < N), 65'd1);
    chk("stream_rx_min", 65'(rx_cnt > 8), 65'd1);
    chk("stream_q0_left", 65'(q0.size()), 65'd0);
    chk("stream_idle0", 65'(pndng_device0), 65'd0);
    chk("stream_idle1", 65'(pndng_device1), 65'd0);

    // backpressure: ninth packet waits behind a full egress 1
    for (int i = 0; i < 8; i++) send(0, {3'b001, 2'b00, 60'(i + 100)});
    send(0, {3'b001, 2'b00, 60'hDEAD});
    tick(); tick(); tick();
    chk("bp_pndng1", 65'(pndng_device1), 65'd1);
    chk("bp_head_held", D_pop_device1, q1[0]);
    chk("bp_pndng0", 65'(pndng_device0), 65'd0);
    pop_one(1);
    drain(1);

    // asynchronous reset mid-operation drops in-flight data immediately
    send(0, {3'b001, 2'b00, 60'h77});
    tick();
    chk("mid_pndng1", 65'(pndng_device1), 65'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_pndng1", 65'(pndng_device1), 65'd0);
    chk("mid_rst_dpop1", D_pop_device1, 65'd0);
    q1.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_after_pndng1", 65'(pndng_device1), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
